// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   tx_data, tx_valid   byte push; accepted on any edge where tx_ready is high
//   tx_ready            combinational, high while the FIFO has a free slot
//   tx                  serial line, 8N1, LSB first, idle high
//   busy                transmitter not idle
//   bit_strobe          pulse on the last cycle of every bit period
//   frame_done          pulse on the last cycle of each stop bit
//   fifo_count          bytes currently queued (not counting the one in flight)
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx,
    output logic                               busy,
    output logic                               bit_strobe,
    output logic                               frame_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW           = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // FIFO storage carries no reset: contents are only read behind a valid count.
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_strobe_q, bit_strobe_d;
    logic             frame_done_q, frame_done_d;

    logic             push;
    logic             pop;
    logic             last_cyc;
    logic [7:0]       head;

    assign tx_ready   = (count_q < DEPTH_C);
    assign push       = tx_valid && tx_ready;
    assign head       = mem_q[rd_ptr_q];
    assign last_cyc   = (bit_cnt_q == LAST_CNT);

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign bit_strobe = bit_strobe_q;
    assign frame_done = frame_done_q;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // Pops are decided from the registered count, so a byte pushed into an
    // empty FIFO is only popped on the following edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (last_cyc) begin
                    bit_cnt_d = '0;
                    bit_idx_d = bit_idx_q + 3'd1;   // wraps 7 -> 0 on exit
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (last_cyc) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs are derived from the next state so that they line
        // up with state_q/bit_cnt_q in the cycle they are visible.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d       = (state_d != IDLE);
        bit_strobe_d = (state_d != IDLE) && (bit_cnt_d == LAST_CNT);
        frame_done_d = (state_d == STOP) && (bit_cnt_d == LAST_CNT);
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            bit_strobe_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            bit_strobe_q <= bit_strobe_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
